// File: rtl/kernel_window_ctrl.sv
// Sliding-window (N x N kernel) stream controller: counts pixels, drives line-buffer
// strobes and flags valid windows. Optional macro BORDER_MASK_EN suppresses partial-border windows.
module kernel_window_ctrl #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned N     = 3,
  parameter int unsigned CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          shift_en,
  output logic [CW-1:0] lb_addr,
  output logic          lb_we,
  output logic          win_valid,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] FILL_ROW = CW'(N - 2);
  localparam logic [CW-1:0] WIN_COL  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic          accept;
  logic          col_wrap;
  logic          win_hit;

  // Handshake: no intake while a window is still waiting on downstream.
  assign in_ready = rst && ((state == FILL) || (state == RUN)) && (!win_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shift_en = accept;
  assign lb_we    = accept;
  assign lb_addr  = col_cnt;
  assign busy     = rst && (state != IDLE);
  assign col_wrap = (col_cnt == COL_LAST);

`ifdef BORDER_MASK_EN
  assign win_hit = accept && (state == RUN) && (col_cnt >= WIN_COL);
`else
  assign win_hit = accept && (state == RUN);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      col_cnt    <= '0;
      row_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        col <= col_cnt;
        row <= row_cnt;
        if (col_wrap) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + CW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end

      // A held window only drops once downstream has taken it.
      if (win_hit) begin
        win_valid <= 1'b1;
      end else if (out_ready) begin
        win_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) state <= FILL;
        end
        FILL: begin
          if (accept && col_wrap && (row_cnt == FILL_ROW)) state <= RUN;
        end
        RUN: begin
          if (accept && col_wrap && (row_cnt == ROW_LAST)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          col_cnt <= '0;
          row_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// Directed bench for kernel_window_ctrl on an 8x4 frame with a 3x3 kernel.
module tb_kernel_window_ctrl;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned N     = 3;
  localparam int unsigned CW    = 6;
`ifdef BORDER_MASK_EN
  localparam int EXP_WIN       = 12;
  localparam int FIRST_WIN_COL = 2;
`else
  localparam int EXP_WIN       = 16;
  localparam int FIRST_WIN_COL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          shift_en;
  logic [CW-1:0] lb_addr;
  logic          lb_we;
  logic          win_valid;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          busy;
  logic          frame_done;

  int passed = 0;
  int total  = 0;

  kernel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .shift_en(shift_en), .lb_addr(lb_addr), .lb_we(lb_we),
    .win_valid(win_valid), .col(col), .row(row), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: tracks the expected pixel sequence and frame statistics.
  int cyc = 0, n_shift = 0, n_win = 0, n_done = 0, lb_err = 0, coord_err = 0;
  int facc = 0, first_acc_cyc = 0, done_cyc = 0, exp_c = 0, exp_r = 0;
  int pend_c = 0, pend_r = 0, first_win_col = -1, first_win_row = -1;
  bit pend = 1'b0, win_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_c = 0; exp_r = 0; pend = 1'b0; facc = 0; win_seen = 1'b0;
    end else begin
      if (pend) begin
        if (col !== CW'(pend_c) || row !== CW'(pend_r)) coord_err++;
        if (win_valid) begin
          n_win++;
          if (!win_seen) begin
            win_seen = 1'b1; first_win_col = int'(col); first_win_row = int'(row);
          end
        end
        pend = 1'b0;
      end
      if (shift_en) begin
        if (lb_addr !== CW'(exp_c) || lb_we !== 1'b1) lb_err++;
        if (facc == 0) first_acc_cyc = cyc;
        facc++;
        n_shift++;
        pend = 1'b1; pend_c = exp_c; pend_r = exp_r;
        if (exp_c == int'(IMG_W) - 1) begin exp_c = 0; exp_r++; end
        else exp_c++;
      end
      if (frame_done) begin
        n_done++; done_cyc = cyc; exp_c = 0; exp_r = 0; facc = 0; win_seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit start_on_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    if (ok && start_on_done) start = 1'b1;
    tick();
    start = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL wait_done: frame_done never seen (got 0, need 1)");
    end
  endtask

  task automatic check_frame(input string tag, input int d_shift, input int d_done,
                             input int d_win, input int d_lb, input int d_coord);
    total++;
    if (d_shift !== 32) $display("FAIL %s shifts: got %0d need 32", tag, d_shift);
    else passed++;
    total++;
    if (d_done !== 1) $display("FAIL %s frame_done count: got %0d need 1", tag, d_done);
    else passed++;
    total++;
    if (d_win !== EXP_WIN) $display("FAIL %s windows: got %0d need %0d", tag, d_win, EXP_WIN);
    else passed++;
    total++;
    if (d_lb !== 0 || d_coord !== 0)
      $display("FAIL %s sequence errors: got lb=%0d coord=%0d need 0", tag, d_lb, d_coord);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b need 0", in_ready); else passed++;
    total++;
    if (shift_en !== 1'b0 || lb_we !== 1'b0)
      $display("FAIL reset strobes: got %b%b need 00", shift_en, lb_we);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b need 0", busy); else passed++;
    total++;
    if ({win_valid, frame_done, col, row, lb_addr} !== '0)
      $display("FAIL reset regs: got wv=%b fd=%b col=%0d row=%0d addr=%0d need zeros",
               win_valid, frame_done, col, row, lb_addr);
    else passed++;
    start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset start ignored: busy got %b need 0", busy); else passed++;
  endtask

  task automatic test_idle_ignore();
    int b_shift;
    b_shift = n_shift;
    in_valid = 1'b1;
    repeat (4) tick();
    total++;
    if (n_shift - b_shift !== 0 || shift_en !== 1'b0)
      $display("FAIL idle shift_en: got %0d shifts need 0", n_shift - b_shift);
    else passed++;
    total++;
    if (lb_addr !== '0 || busy !== 1'b0)
      $display("FAIL idle state: got addr=%0d busy=%b need 0/0", lb_addr, busy);
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_basic_frame();
    int b_shift, b_done, b_win, b_lb, b_co;
    bit ok;
    b_shift = n_shift; b_done = n_done; b_win = n_win; b_lb = lb_err; b_co = coord_err;
    in_valid = 1'b1; out_ready = 1'b1;
    start_frame();
    wait_done(1'b0, ok);
    in_valid = 1'b0;
    check_frame("basic", n_shift - b_shift, n_done - b_done, n_win - b_win,
                lb_err - b_lb, coord_err - b_co);
    total++;
    if (first_win_col !== FIRST_WIN_COL || first_win_row !== 2)
      $display("FAIL basic first window: got (%0d,%0d) need (2,%0d)",
               first_win_row, first_win_col, FIRST_WIN_COL);
    else passed++;
    total++;
    if (done_cyc - first_acc_cyc + 1 !== 33)
      $display("FAIL basic done latency: got %0d need 33", done_cyc - first_acc_cyc + 1);
    else passed++;
    total++;
    if (busy !== 1'b0 || lb_addr !== '0)
      $display("FAIL basic after done: got busy=%b addr=%0d need 0/0", busy, lb_addr);
    else passed++;
  endtask

  task automatic test_backpressure();
    int b_shift, b_done, b_win, b_lb, b_co;
    bit ok, found;
    b_shift = n_shift; b_done = n_done; b_win = n_win; b_lb = lb_err; b_co = coord_err;
    in_valid = 1'b1; out_ready = 1'b1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (win_valid && col == CW'(3) && row == CW'(2)) begin found = 1'b1; break; end
    end
    total++;
    if (!found) $display("FAIL bp window (2,3): got none need 1");
    else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({win_valid, col, row} !== {1'b1, CW'(4), CW'(2)})
        $display("FAIL bp hold: got wv=%b col=%0d row=%0d need 1/4/2", win_valid, col, row);
      else passed++;
      total++;
      if (in_ready !== 1'b0 || shift_en !== 1'b0)
        $display("FAIL bp stall: got rdy=%b shift=%b need 0/0", in_ready, shift_en);
      else passed++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(1'b0, ok);
    in_valid = 1'b0;
    check_frame("bp", n_shift - b_shift, n_done - b_done, n_win - b_win,
                lb_err - b_lb, coord_err - b_co);
  endtask

  task automatic test_gapped();
    int b_shift, b_done, b_win, b_lb, b_co;
    bit ok;
    b_shift = n_shift; b_done = n_done; b_win = n_win; b_lb = lb_err; b_co = coord_err;
    in_valid = 1'b0; out_ready = 1'b1;
    start_frame();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL gapped done: got 0 need 1"); else passed++;
    check_frame("gapped", n_shift - b_shift, n_done - b_done, n_win - b_win,
                lb_err - b_lb, coord_err - b_co);
  endtask

  task automatic test_reset_midframe();
    int b_shift, b_done, b_win, b_lb, b_co;
    bit ok;
    in_valid = 1'b1; out_ready = 1'b1;
    b_shift = n_shift;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      if (n_shift - b_shift >= 19) break;
      tick();
    end
    total++;
    if (lb_addr !== CW'(3) || n_shift - b_shift !== 19)
      $display("FAIL midrst position: got addr=%0d accepts=%0d need 3/19", lb_addr, n_shift - b_shift);
    else passed++;
    b_done = n_done;
    rst = 1'b0;
    tick();
    total++;
    if ({busy, win_valid, frame_done, in_ready} !== 4'b0000)
      $display("FAIL midrst state: got busy=%b wv=%b fd=%b rdy=%b need 0000",
               busy, win_valid, frame_done, in_ready);
    else passed++;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (n_done - b_done !== 0 || busy !== 1'b0 || {col, row} !== '0)
      $display("FAIL midrst aftermath: got done=%0d busy=%b col=%0d row=%0d need 0/0/0/0",
               n_done - b_done, busy, col, row);
    else passed++;
    b_shift = n_shift; b_done = n_done; b_win = n_win; b_lb = lb_err; b_co = coord_err;
    start_frame();
    @(negedge clk);
    total++;
    if (shift_en !== 1'b1 || lb_addr !== '0)
      $display("FAIL midrst restart: got shift=%b addr=%0d need 1/0", shift_en, lb_addr);
    else passed++;
    wait_done(1'b0, ok);
    in_valid = 1'b0;
    check_frame("restart", n_shift - b_shift, n_done - b_done, n_win - b_win,
                lb_err - b_lb, coord_err - b_co);
  endtask

  task automatic test_ignored_start();
    int b_shift, b_done, b_win, b_lb, b_co;
    bit ok;
    b_shift = n_shift; b_done = n_done; b_win = n_win; b_lb = lb_err; b_co = coord_err;
    in_valid = 1'b1; out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      if (n_shift - b_shift >= 20) break;
      tick();
    end
    start_frame();
    wait_done(1'b1, ok);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL start on frame_done: got busy=%b need 0", busy); else passed++;
    tick();
    total++;
    if (busy !== 1'b0 || lb_addr !== '0)
      $display("FAIL idle after done: got busy=%b addr=%0d need 0/0", busy, lb_addr);
    else passed++;
    check_frame("start_in_run", n_shift - b_shift, n_done - b_done, n_win - b_win,
                lb_err - b_lb, coord_err - b_co);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_idle_ignore();
    test_basic_frame();
    test_backpressure();
    test_gapped();
    test_reset_midframe();
    test_ignored_start();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/kernel_window_ctrl.md
KERNEL_WINDOW_CTRL -- requirements
Module: kernel_window_ctrl

Interface
REQ-001 Parameters SHALL be:
- IMG_W, default 64, pixels per image row.
- IMG_H, default 64, rows per frame.
- N, default 3, kernel side length.
- CW, default 6, counter width; CW SHALL be at least clog2(max(IMG_W, IMG_H)).

REQ-002 Ports SHALL be:
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, pulse that begins a frame; ignored unless in IDLE.
- in_valid, in, 1, upstream pixel valid.
- in_ready, out, 1, controller can accept a pixel.
- out_ready, in, 1, downstream accepts the window.
- shift_en, out, 1, advance the window shift registers and line buffers.
- lb_addr, out, CW, line-buffer read/write column address.
- lb_we, out, 1, line-buffer write strobe.
- win_valid, out, 1, window contents are a valid kernel output.
- col, out, CW, column of the pixel last accepted.
- row, out, CW, row of the pixel last accepted.
- busy, out, 1, state is not IDLE.
- frame_done, out, 1, one-cycle pulse after the last pixel of the frame.

Function
REQ-003 The FSM SHALL have four states: IDLE, FILL, RUN, DONE.
REQ-004 IDLE SHALL go to FILL on start=1; all other states SHALL ignore start.
REQ-005 accept SHALL be in_valid & in_ready.
REQ-006 in_ready SHALL be 1 only in FILL or RUN, and only when (win_valid=0 or out_ready=1).
REQ-007 shift_en and lb_we SHALL equal accept, combinationally, in the same cycle.
REQ-008 lb_addr SHALL equal the column counter value for the pixel being accepted.
REQ-009 On each accept the column counter SHALL increment. At IMG_W-1 it SHALL wrap to 0 and the row counter SHALL increment.
REQ-010 FILL SHALL go to RUN on the accept that completes row N-2 (that is, wrapping col while row = N-2).
REQ-011 RUN SHALL go to DONE on the accept of pixel (row = IMG_H-1, col = IMG_W-1).
REQ-012 DONE SHALL last exactly one cycle, assert frame_done=1, clear both counters, and return to IDLE.
REQ-013 win_valid SHALL be registered, with one cycle of latency after the accept that produced it.
REQ-014 win_valid SHALL hold its value while out_ready=0. It SHALL clear on the first cycle with out_ready=1 and no new qualifying accept.
REQ-015 The col and row outputs SHALL be registered copies of the accepted pixel's coordinates, updated together with win_valid.
REQ-016 in_valid=1 while in IDLE or DONE SHALL have no effect: no shift_en and no counter change.
REQ-017 A start pulse arriving in the same cycle as frame_done SHALL be ignored.

Reset
REQ-018 With rst=0 on a clock edge:
- state SHALL become IDLE.
- The counters, col, row, win_valid and frame_done SHALL become 0.
- rst SHALL take priority over every other input.
REQ-019 During reset and in IDLE, in_ready, shift_en, lb_we and busy SHALL be 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse. The next frame SHALL restart at (0,0) after a new start.

Configuration
REQ-021 Macro BORDER_MASK_EN SHALL select how the image border is handled:
- Defined: win_valid SHALL be set only for accepts in RUN with col >= N-1, so horizontally partial windows are suppressed.
- Undefined: win_valid SHALL be set for every accept in RUN, and downstream handles the border.
REQ-022 The port list SHALL be identical in both builds.

Verification
REQ-023 Basic frame, IMG_W=8, IMG_H=4, N=3, in_valid held at 1, out_ready=1, pulse start:
- Expect 32 shift_en pulses.
- Expect FILL for the first 16 accepts.
- Expect exactly one frame_done, 33 cycles after the first accept.
REQ-024 Window counts for the same frame:
- BORDER_MASK_EN defined: exactly 12 win_valid cycles.
- BORDER_MASK_EN undefined: exactly 16 win_valid cycles.
REQ-025 Backpressure: drive out_ready=0 for 5 cycles while win_valid=1.
- win_valid, col and row SHALL hold.
- in_ready SHALL be 0 and there SHALL be no shift_en.
- The frame SHALL complete correctly after out_ready returns to 1.
REQ-026 Gapped input: in_valid toggling 1,0,1,0 SHALL still give a final count of 32 accepts.
- lb_addr SHALL sequence 0..7 on each row.
- No pixel SHALL be lost or duplicated.
REQ-027 Reset mid-frame: assert rst=0 at row=2, col=3.
- Next cycle SHALL show state IDLE, win_valid=0, busy=0 and no frame_done.
- A following start SHALL restart at (0,0).
REQ-028 Ignored inputs:
- start asserted while in RUN SHALL be ignored.
- in_valid=1 in IDLE SHALL produce no shift_en and no counter change.
